// File: rtl/calc_pkg.sv
// calc_pkg: instruction classes, ALU/condition codes, FSM states and field positions for calc_unit
// No ports; imported by calc_if users and calc_unit.
package calc_pkg;

    typedef enum logic [1:0] {IMM, CALC, COPY, COND} opclass_e;
    typedef enum logic [2:0] {OP_OR, OP_NAND, OP_NOR, OP_AND, OP_ADD, OP_SUB, OP_MUL, OP_XOR} alu_op_e;
    typedef enum logic [2:0] {C_NEVER, C_EQZ, C_LTZ, C_LEZ, C_ALWAYS, C_NEZ, C_GEZ, C_GTZ} cond_e;
    typedef enum logic {S_IDLE, S_MUL} state_e;

    localparam int CLS_LSB = 6;
    localparam int IMM_W   = 6;
    localparam int SRC_LSB = 3;
    localparam int DST_LSB = 0;
    localparam int OP_LSB  = 0;

    // Codes 4..7 are the negations of codes 0..3, so only the low two bits pick a test.
    function automatic logic cond_eval(cond_e c, logic neg, logic zero);
        logic base;
        base = c[1:0] == 2'd0 ? 1'b0 :
               c[1:0] == 2'd1 ? zero :
               c[1:0] == 2'd2 ? neg : (neg | zero);
        return c[2] ^ base;
    endfunction

endpackage

// File: rtl/calc_if.sv
// calc_if: instruction handshake, input port, output port and status signals of calc_unit
// master: fetch/environment side (drives inst, inst_valid, in_data, in_valid)
// slave : calc_unit side (drives inst_ready, in_ready, out_data, out_valid, result, result_valid, cond_true, busy)
interface calc_if #(parameter int WIDTH = 8);

    logic [7:0]       inst;
    logic             inst_valid;
    logic             inst_ready;
    logic [WIDTH-1:0] in_data;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] out_data;
    logic             out_valid;
    logic [WIDTH-1:0] result;
    logic             result_valid;
    logic             cond_true;
    logic             busy;

    modport master (
        output inst, inst_valid, in_data, in_valid,
        input  inst_ready, in_ready, out_data, out_valid, result, result_valid, cond_true, busy
    );

    modport slave (
        input  inst, inst_valid, in_data, in_valid,
        output inst_ready, in_ready, out_data, out_valid, result, result_valid, cond_true, busy
    );

endinterface

// File: rtl/calc_mul_seq.sv
// calc_mul_seq: WIDTH-cycle shift-add multiplier returning the low WIDTH bits of i_a*i_b
// clk, rst  : clock, asynchronous active-high reset
// i_start   : latch operands and begin
// i_a, i_b  : multiplicand, multiplier
// o_done    : high during the last step; o_product is valid in that cycle
// o_product : low WIDTH bits of the product
module calc_mul_seq #(parameter int WIDTH = 8) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_start,
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    output logic             o_done,
    output logic [WIDTH-1:0] o_product
);

    localparam int CW = $clog2(WIDTH);

    logic [WIDTH-1:0] r_a, r_b, r_acc;
    logic [CW-1:0]    r_cnt;
    logic             r_run;
    logic [WIDTH-1:0] w_sum;

    // The final accumulation is exposed combinationally so the caller can
    // write it on the same edge that consumes the last multiplier bit.
    assign w_sum     = r_acc + (r_b[0] ? r_a : '0);
    assign o_done    = r_run && r_cnt == '0;
    assign o_product = w_sum;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_a   <= '0;
            r_b   <= '0;
            r_acc <= '0;
            r_cnt <= '0;
            r_run <= 1'b0;
        end else if (i_start) begin
            r_a   <= i_a;
            r_b   <= i_b;
            r_acc <= '0;
            r_cnt <= CW'(WIDTH - 1);
            r_run <= 1'b1;
        end else if (r_run) begin
            r_acc <= w_sum;
            r_a   <= r_a << 1;
            r_b   <= r_b >> 1;
            r_cnt <= r_cnt - 1'b1;
            r_run <= r_cnt != '0;
        end
    end

endmodule

// File: rtl/calc_unit.sv
// calc_unit: decodes 8-bit instructions and executes them on a register file, ALU and I/O register
// clk, rst : clock, asynchronous active-high reset
// bus      : calc_if slave (instruction handshake, input port, output port, result, cond_true, busy)
module calc_unit
    import calc_pkg::*;
#(
    parameter int WIDTH  = 8,
    parameter int NREGS  = 8,
    parameter int IO_IDX = 6,
    parameter int MUL_EN = 1
) (
    input logic   clk,
    input logic   rst,
    calc_if.slave bus
);

    state_e           r_state;
    logic [WIDTH-1:0] r_regs [8];
    logic [WIDTH-1:0] r_result, r_out_data;
    logic             r_result_valid, r_out_valid, r_in_ready, r_cond;

    opclass_e         w_cls;
    alu_op_e          w_op;
    logic [2:0]       w_src, w_dst;
    logic [WIDTH-1:0] w_a, w_b, w_alu, w_src_val, w_mul_prod;
    logic             w_io_stall, w_accept, w_mul_start, w_mul_done;

    assign w_cls = opclass_e'(bus.inst[CLS_LSB +: 2]);
    assign w_op  = alu_op_e'(bus.inst[OP_LSB +: 3]);
    assign w_src = bus.inst[SRC_LSB +: 3];
    assign w_dst = bus.inst[DST_LSB +: 3];
    assign w_a   = r_regs[1];
    assign w_b   = r_regs[2];

    // The I/O index has no storage: reads see the input port; unimplemented entries read 0.
    assign w_src_val = int'(w_src) == IO_IDX ? bus.in_data :
                       int'(w_src) < NREGS   ? r_regs[w_src] : '0;

    // A copy from the input port cannot complete without data, so hold it off.
    assign w_io_stall     = w_cls == COPY && int'(w_src) == IO_IDX && !bus.in_valid;
    assign bus.inst_ready = r_state == S_IDLE && !w_io_stall;
    assign w_accept       = bus.inst_valid && bus.inst_ready;
    assign w_mul_start    = w_accept && w_cls == CALC && w_op == OP_MUL && MUL_EN != 0;

    always_comb begin
        w_alu = '0;
        case (w_op)
            OP_OR:   w_alu = w_a | w_b;
            OP_NAND: w_alu = ~(w_a & w_b);
            OP_NOR:  w_alu = ~(w_a | w_b);
            OP_AND:  w_alu = w_a & w_b;
            OP_ADD:  w_alu = w_a + w_b;
            OP_SUB:  w_alu = w_a - w_b;
            OP_XOR:  w_alu = w_a ^ w_b;
            default: w_alu = '0;
        endcase
    end

    if (MUL_EN != 0) begin : g_mul
        calc_mul_seq #(.WIDTH(WIDTH)) u_mul (
            .clk       (clk),
            .rst       (rst),
            .i_start   (w_mul_start),
            .i_a       (w_a),
            .i_b       (w_b),
            .o_done    (w_mul_done),
            .o_product (w_mul_prod)
        );
    end else begin : g_nomul
        assign w_mul_done = 1'b0;
        assign w_mul_prod = '0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state        <= S_IDLE;
            r_regs         <= '{default: '0};
            r_result       <= '0;
            r_out_data     <= '0;
            r_result_valid <= 1'b0;
            r_out_valid    <= 1'b0;
            r_in_ready     <= 1'b0;
            r_cond         <= 1'b0;
        end else begin
            r_result_valid <= 1'b0;
            r_out_valid    <= 1'b0;
            r_in_ready     <= 1'b0;
            if (w_accept) begin
                case (w_cls)
                    IMM: r_regs[0] <= WIDTH'(bus.inst[IMM_W-1:0]);
                    CALC: begin
                        if (w_mul_start) begin
                            r_state <= S_MUL;
                        end else begin
                            r_regs[3]      <= w_alu;
                            r_result       <= w_alu;
                            r_result_valid <= 1'b1;
                        end
                    end
                    COPY: begin
                        r_in_ready <= int'(w_src) == IO_IDX;
                        if (int'(w_dst) == IO_IDX) begin
                            r_out_data  <= w_src_val;
                            r_out_valid <= 1'b1;
                        end else if (int'(w_dst) < NREGS) begin
                            r_regs[w_dst] <= w_src_val;
                        end
                    end
                    default: r_cond <= cond_eval(cond_e'(bus.inst[2:0]), r_regs[3][WIDTH-1], r_regs[3] == '0);
                endcase
            end else if (r_state == S_MUL && w_mul_done) begin
                r_regs[3]      <= w_mul_prod;
                r_result       <= w_mul_prod;
                r_result_valid <= 1'b1;
                r_state        <= S_IDLE;
            end
        end
    end

    assign bus.in_ready     = r_in_ready;
    assign bus.out_data     = r_out_data;
    assign bus.out_valid    = r_out_valid;
    assign bus.result       = r_result;
    assign bus.result_valid = r_result_valid;
    assign bus.cond_true    = r_cond;
    assign bus.busy         = r_state == S_MUL;

endmodule

// File: tb/tb_calc_unit.sv
// tb_calc_unit: self-checking bench for calc_unit (WIDTH=8 with multiply, WIDTH=16 without)
module tb_calc_unit;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    calc_if #(.WIDTH(8))  b8 ();
    calc_if #(.WIDTH(16)) b16 ();

    calc_unit #(.WIDTH(8), .NREGS(8), .IO_IDX(6), .MUL_EN(1)) dut8 (.clk(clk), .rst(rst), .bus(b8));
    calc_unit #(.WIDTH(16), .NREGS(8), .IO_IDX(6), .MUL_EN(0)) dut16 (.clk(clk), .rst(rst), .bus(b16));

    typedef struct packed {
        logic [7:0]  inst;
        logic [15:0] din;
        logic        rv;
        logic [15:0] res;
        logic        ov;
        logic [15:0] od;
        logic        ir;
        logic        ct;
    } vec_t;

    vec_t tbl8[$];
    vec_t tbl16[$];

    int n_chk = 0;
    int n_fail = 0;
    int nb, bad, k;
    int m_reg [8];
    int m_res, m_od, m_ct, cls, src, dst, srcv, s, a, b;
    logic [7:0] ri, rdat;
    logic riv, blocked;

    function automatic vec_t v(logic [7:0] i, logic [15:0] din, logic rv, logic [15:0] res,
                               logic ov, logic [15:0] od, logic ir, logic ct);
        return '{i, din, rv, res, ov, od, ir, ct};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic issue8(input logic [7:0] i);
        int w = 0;
        b8.inst = i;
        b8.inst_valid = 1'b1;
        #1;
        while (!b8.inst_ready && w < 50) begin
            @(posedge clk); #1;
            w++;
        end
        if (w >= 50) begin
            n_chk++;
            n_fail++;
            $display("FAIL issue8: inst %h never accepted", i);
        end
        @(posedge clk); #1;
        b8.inst_valid = 1'b0;
    endtask

    task automatic issue16(input logic [7:0] i);
        int w = 0;
        b16.inst = i;
        b16.inst_valid = 1'b1;
        #1;
        while (!b16.inst_ready && w < 50) begin
            @(posedge clk); #1;
            w++;
        end
        if (w >= 50) begin
            n_chk++;
            n_fail++;
            $display("FAIL issue16: inst %h never accepted", i);
        end
        @(posedge clk); #1;
        b16.inst_valid = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        b8.inst = '0;  b8.inst_valid = 1'b0;  b8.in_data = '0;  b8.in_valid = 1'b0;
        b16.inst = '0; b16.inst_valid = 1'b0; b16.in_data = '0; b16.in_valid = 1'b0;

        // inst, din, rv, res, ov, od, ir, ct  (res/od/ct are the held values)
        tbl8.push_back(v(8'h05, 0, 0, 16'h00, 0, 16'h00, 0, 0));
        tbl8.push_back(v(8'h81, 0, 0, 16'h00, 0, 16'h00, 0, 0));
        tbl8.push_back(v(8'h03, 0, 0, 16'h00, 0, 16'h00, 0, 0));
        tbl8.push_back(v(8'h82, 0, 0, 16'h00, 0, 16'h00, 0, 0));
        tbl8.push_back(v(8'h44, 0, 1, 16'h08, 0, 16'h00, 0, 0));
        tbl8.push_back(v(8'h9E, 0, 0, 16'h08, 1, 16'h08, 0, 0));
        tbl8.push_back(v(8'hC2, 0, 0, 16'h08, 0, 16'h08, 0, 0));
        tbl8.push_back(v(8'hC7, 0, 0, 16'h08, 0, 16'h08, 0, 1));
        tbl8.push_back(v(8'hC1, 0, 0, 16'h08, 0, 16'h08, 0, 0));
        tbl8.push_back(v(8'hC6, 0, 0, 16'h08, 0, 16'h08, 0, 1));
        tbl8.push_back(v(8'h91, 0, 0, 16'h08, 0, 16'h08, 0, 1));
        tbl8.push_back(v(8'h05, 0, 0, 16'h08, 0, 16'h08, 0, 1));
        tbl8.push_back(v(8'h82, 0, 0, 16'h08, 0, 16'h08, 0, 1));
        tbl8.push_back(v(8'h45, 0, 1, 16'hFE, 0, 16'h08, 0, 1));
        tbl8.push_back(v(8'hC2, 0, 0, 16'hFE, 0, 16'h08, 0, 1));
        tbl8.push_back(v(8'hC7, 0, 0, 16'hFE, 0, 16'h08, 0, 0));
        tbl8.push_back(v(8'hC3, 0, 0, 16'hFE, 0, 16'h08, 0, 1));
        tbl8.push_back(v(8'hC0, 0, 0, 16'hFE, 0, 16'h08, 0, 0));
        tbl8.push_back(v(8'hC4, 0, 0, 16'hFE, 0, 16'h08, 0, 1));
        tbl8.push_back(v(8'hC5, 0, 0, 16'hFE, 0, 16'h08, 0, 1));
        tbl8.push_back(v(8'h40, 0, 1, 16'h07, 0, 16'h08, 0, 1));
        tbl8.push_back(v(8'h41, 0, 1, 16'hFE, 0, 16'h08, 0, 1));
        tbl8.push_back(v(8'h42, 0, 1, 16'hF8, 0, 16'h08, 0, 1));
        tbl8.push_back(v(8'h43, 0, 1, 16'h01, 0, 16'h08, 0, 1));
        tbl8.push_back(v(8'h47, 0, 1, 16'h06, 0, 16'h08, 0, 1));
        tbl8.push_back(v(8'hB6, 16'h5A, 0, 16'h06, 1, 16'h5A, 1, 1));
        tbl8.push_back(v(8'hB3, 16'h80, 0, 16'h06, 0, 16'h5A, 1, 1));
        tbl8.push_back(v(8'hC2, 0, 0, 16'h06, 0, 16'h5A, 0, 1));
        tbl8.push_back(v(8'h9E, 0, 0, 16'h06, 1, 16'h80, 0, 1));

        tbl16.push_back(v(8'h42, 0, 1, 16'hFFFF, 0, 0, 0, 0));
        tbl16.push_back(v(8'h99, 0, 0, 16'hFFFF, 0, 0, 0, 0));
        tbl16.push_back(v(8'h01, 0, 0, 16'hFFFF, 0, 0, 0, 0));
        tbl16.push_back(v(8'h82, 0, 0, 16'hFFFF, 0, 0, 0, 0));
        tbl16.push_back(v(8'h46, 0, 1, 16'h0000, 0, 0, 0, 0));
        tbl16.push_back(v(8'h44, 0, 1, 16'h0000, 0, 0, 0, 0));
        tbl16.push_back(v(8'h45, 0, 1, 16'hFFFE, 0, 0, 0, 0));
        tbl16.push_back(v(8'hC2, 0, 0, 16'hFFFE, 0, 0, 0, 1));

        // reset state
        repeat (2) @(posedge clk);
        #1;
        chk("rst result", b8.result, 0);
        chk("rst result_valid", b8.result_valid, 0);
        chk("rst out_data", b8.out_data, 0);
        chk("rst out_valid", b8.out_valid, 0);
        chk("rst in_ready", b8.in_ready, 0);
        chk("rst cond_true", b8.cond_true, 0);
        chk("rst busy", b8.busy, 0);
        rst = 1'b0;

        // single-cycle table, WIDTH=8
        foreach (tbl8[i]) begin
            b8.in_valid = 1'b1;
            b8.in_data = tbl8[i].din[7:0];
            issue8(tbl8[i].inst);
            chk($sformatf("t8[%0d] result_valid", i), b8.result_valid, tbl8[i].rv);
            chk($sformatf("t8[%0d] result", i), b8.result, tbl8[i].res);
            chk($sformatf("t8[%0d] out_valid", i), b8.out_valid, tbl8[i].ov);
            chk($sformatf("t8[%0d] out_data", i), b8.out_data, tbl8[i].od);
            chk($sformatf("t8[%0d] in_ready", i), b8.in_ready, tbl8[i].ir);
            chk($sformatf("t8[%0d] cond_true", i), b8.cond_true, tbl8[i].ct);
            chk($sformatf("t8[%0d] busy", i), b8.busy, 0);
        end

        // multiply 13*11 with a pending instruction held behind it
        issue8(8'h0D); issue8(8'h81); issue8(8'h0B); issue8(8'h82);
        b8.inst = 8'h46;
        b8.inst_valid = 1'b1;
        @(posedge clk); #1;
        b8.inst = 8'h9E;
        nb = 0;
        bad = 0;
        for (int j = 0; j < 40 && b8.busy; j++) begin
            if (b8.inst_ready || b8.out_valid || b8.result_valid) bad++;
            nb++;
            @(posedge clk); #1;
        end
        chk("mul busy cycles", nb, 8);
        chk("mul stalled", bad, 0);
        chk("mul result_valid", b8.result_valid, 1);
        chk("mul result", b8.result, 8'h8F);
        chk("mul inst_ready after", b8.inst_ready, 1);
        @(posedge clk); #1;
        b8.inst_valid = 1'b0;
        chk("mul pending out_valid", b8.out_valid, 1);
        chk("mul pending out_data", b8.out_data, 8'h8F);

        // input back-pressure
        b8.in_valid = 1'b0;
        b8.inst = 8'hB1;
        b8.inst_valid = 1'b1;
        bad = 0;
        for (int j = 0; j < 3; j++) begin
            #1;
            if (b8.inst_ready) bad++;
            @(posedge clk); #1;
            if (b8.in_ready) bad++;
        end
        chk("io stall", bad, 0);
        b8.in_valid = 1'b1;
        b8.in_data = 8'h2A;
        #1;
        chk("io ready", b8.inst_ready, 1);
        @(posedge clk); #1;
        b8.inst_valid = 1'b0;
        chk("io in_ready pulse", b8.in_ready, 1);
        @(posedge clk); #1;
        chk("io in_ready drop", b8.in_ready, 0);
        issue8(8'h8E);
        chk("io out_valid", b8.out_valid, 1);
        chk("io out_data", b8.out_data, 8'h2A);

        // WIDTH=16 without multiplier
        foreach (tbl16[i]) begin
            issue16(tbl16[i].inst);
            chk($sformatf("t16[%0d] result_valid", i), b16.result_valid, tbl16[i].rv);
            chk($sformatf("t16[%0d] result", i), b16.result, tbl16[i].res);
            chk($sformatf("t16[%0d] cond_true", i), b16.cond_true, tbl16[i].ct);
            chk($sformatf("t16[%0d] busy", i), b16.busy, 0);
            chk($sformatf("t16[%0d] inst_ready", i), b16.inst_ready, 1);
        end

        // reset in the middle of a multiply
        b8.inst = 8'h46;
        b8.inst_valid = 1'b1;
        @(posedge clk); #1;
        b8.inst_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rstmul busy before", b8.busy, 1);
        rst = 1'b1;
        #1;
        chk("rstmul busy", b8.busy, 0);
        chk("rstmul result_valid", b8.result_valid, 0);
        chk("rstmul result", b8.result, 0);
        chk("rstmul out_data", b8.out_data, 0);
        chk("rstmul cond_true", b8.cond_true, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        bad = 0;
        for (int j = 0; j < 10; j++) begin
            @(posedge clk); #1;
            if (b8.result_valid || b8.busy) bad++;
        end
        chk("rstmul discarded", bad, 0);
        issue8(8'h9E);
        chk("rstmul reg3", b8.out_data, 0);
        issue8(8'h8E);
        chk("rstmul reg1", b8.out_data, 0);
        issue8(8'h01);
        issue8(8'h86);
        chk("rstmul imm1 out_valid", b8.out_valid, 1);
        chk("rstmul imm1", b8.out_data, 1);

        // randomized run against a behavioural model, from a fresh reset
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        foreach (m_reg[i]) m_reg[i] = 0;
        m_res = 0;
        m_od = 0;
        m_ct = 0;
        for (int n = 0; n < 300; n++) begin
            ri = 8'($urandom);
            riv = $urandom_range(0, 3) != 0;
            rdat = 8'($urandom);
            cls = int'(ri[7:6]);
            src = int'(ri[5:3]);
            dst = int'(ri[2:0]);
            b8.in_valid = riv;
            b8.in_data = rdat;
            b8.inst = ri;
            b8.inst_valid = 1'b1;
            #1;
            blocked = cls == 2 && src == 6 && !riv;
            chk("rnd inst_ready", b8.inst_ready, !blocked);
            if (blocked) begin
                @(posedge clk); #1;
                chk("rnd stall pulses", {b8.in_ready, b8.out_valid, b8.result_valid}, 0);
                b8.in_valid = 1'b1;
                #1;
            end
            @(posedge clk); #1;
            b8.inst_valid = 1'b0;
            srcv = src == 6 ? int'(rdat) : m_reg[src];
            a = m_reg[1];
            b = m_reg[2];
            if (cls == 0) m_reg[0] = int'(ri[5:0]);
            if (cls == 1) begin
                case (dst)
                    0: m_res = a | b;
                    1: m_res = 255 - (a & b);
                    2: m_res = 255 - (a | b);
                    3: m_res = a & b;
                    4: m_res = (a + b) % 256;
                    5: m_res = (a - b + 256) % 256;
                    6: m_res = (a * b) % 256;
                    default: m_res = a ^ b;
                endcase
                m_reg[3] = m_res;
            end
            if (cls == 2) begin
                if (dst == 6) m_od = srcv;
                else m_reg[dst] = srcv;
            end
            if (cls == 3) begin
                s = m_reg[3] > 127 ? m_reg[3] - 256 : m_reg[3];
                case (dst)
                    0: m_ct = 0;
                    1: m_ct = int'(s == 0);
                    2: m_ct = int'(s < 0);
                    3: m_ct = int'(s <= 0);
                    4: m_ct = 1;
                    5: m_ct = int'(s != 0);
                    6: m_ct = int'(s >= 0);
                    default: m_ct = int'(s > 0);
                endcase
            end
            if (cls == 1 && dst == 6) begin
                k = 0;
                while (!b8.result_valid && k < 40) begin
                    @(posedge clk); #1;
                    k++;
                end
                chk("rnd mul latency", k, 8);
            end
            chk("rnd result_valid", b8.result_valid, cls == 1);
            chk("rnd result", b8.result, m_res);
            chk("rnd out_valid", b8.out_valid, cls == 2 && dst == 6);
            chk("rnd out_data", b8.out_data, m_od);
            chk("rnd in_ready", b8.in_ready, cls == 2 && src == 6);
            chk("rnd cond_true", b8.cond_true, m_ct);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/calc_unit.md
Name: calc_unit

Overview:
- Parametrised successor of the calculation stage: decodes 8-bit instructions and executes them against a register file, an ALU and the I/O register.
- Adds configurable data width and register count, a valid/ready instruction handshake, and an input port with back-pressure.
- Adds a multi-cycle shift-add multiply and a registered condition/branch flag.
- Sits between the fetch stage (supplies instructions) and the program-counter logic (consumes cond_true).

Parameters:
- WIDTH, 8, data and register width (>=6).
- NREGS, 8, register-file entries; index field is 3 bits, so at most 8.
- IO_IDX, 6, register index mapped to in_data on read and out_data on write; no storage.
- MUL_EN, 1, when 1 ALU op 6 is a multi-cycle multiply; when 0, op 6 writes 0 in one cycle.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous, active-high reset.
- inst  in  8  instruction.
- inst_valid  in  1  instruction present.
- inst_ready  out  1  instruction accepted this cycle when inst_valid=1.
- in_data  in  WIDTH  external input value.
- in_valid  in  1  in_data present.
- in_ready  out  1  pulses for the cycle in which in_data is consumed.
- out_data  out  WIDTH  value written to IO_IDX.
- out_valid  out  1  one-cycle pulse accompanying out_data.
- result  out  WIDTH  last ALU result.
- result_valid  out  1  one-cycle pulse when an ALU result is written.
- cond_true  out  1  registered outcome of the last condition instruction.
- busy  out  1  multiply in progress.

Behaviour:
- Decode: inst[7:6] selects the class.
  - 00 IMM: reg0 <= zero-extended inst[5:0].
  - 01 CALC: reg3 <= reg1 op reg2, op = inst[2:0].
  - 10 COPY: reg[inst[2:0]] <= reg[inst[5:3]].
  - 11 COND: evaluate condition inst[2:0] on reg3.
- ALU ops: 0 OR, 1 NAND, 2 NOR, 3 AND, 4 ADD, 5 SUB (reg1-reg2), 6 MUL, 7 XOR.
  - Result is the low WIDTH bits; carry/borrow is discarded.
- Condition codes, reg3 treated as signed WIDTH-bit: 0 never, 1 ==0, 2 <0, 3 <=0, 4 always, 5 !=0, 6 >=0, 7 >0.
  - cond_true updates one cycle after acceptance and holds until the next COND.
- Acceptance: an instruction is accepted on a rising edge with inst_valid && inst_ready.
- inst_ready = (state==IDLE) && !(COPY with src==IO_IDX && !in_valid). It depends combinationally on inst, so the fetch stage must hold inst stable while inst_valid is high.
- Single-cycle instructions: register write is visible at edge N+1, where N is the accept edge. result_valid, out_valid and in_ready assert for exactly the cycle after acceptance. Back-to-back instructions read updated values.
- COPY with src==IO_IDX: reads in_data; in_ready pulses.
- COPY with dst==IO_IDX: drives out_data <= source and pulses out_valid; no register write.
- COPY with src==dst==IO_IDX: passes in_data to out_data.
- COPY with src!=IO_IDX and src>=NREGS: reads 0.
- COPY with dst!=IO_IDX and dst>=NREGS: write discarded.
- State machine IDLE/MUL:
  - MUL accepted → operands latched, state MUL, busy=1, inst_ready=0, counter=WIDTH-1.
  - Each cycle in MUL processes one multiplier bit.
  - When the counter reaches 0: write reg3, pulse result_valid, return to IDLE.
  - Total latency is WIDTH cycles from accept to write. With WIDTH=8, accept at edge N gives the write at edge N+8.
  - Register-file writes other than reg3 cannot occur during MUL, since no instruction is accepted.
- Reset, asynchronous at any time, including mid-MUL:
  - All registers = 0, state IDLE, counter 0.
  - result = 0, out_data = 0, all pulse outputs 0, cond_true 0, busy 0.
  - Any in-flight multiply is discarded.
- inst_valid with an unacceptable instruction: no side effects; the instruction stays pending.

Decomposition:
- calc_pkg holds:
  - opclass_e {IMM, CALC, COPY, COND};
  - alu_op_e;
  - cond_e;
  - field-slice constants for inst.
- Sub-module calc_mul_seq: shift-add multiplier, WIDTH-parametrised, with start/done and asynchronous reset. calc_unit instantiates it under MUL_EN.

Test Plan:
- WIDTH=8: IMM 5, COPY 0→1, IMM 3, COPY 0→2, CALC ADD → reg3=8, result_valid one cycle after acceptance, result=8.
- CALC SUB with reg1=3, reg2=5 → reg3=0xFE; COND "<0" → cond_true=1; COND ">0" → cond_true=0.
- MUL with reg1=13, reg2=11 → busy=1 and inst_ready=0 for 8 cycles; reg3=143 (0x8F). Next instruction held at inst_valid=1 is accepted only after busy drops.
- COPY 6→1 with in_valid=0 for 3 cycles → inst_ready=0, no in_ready. Then in_valid=1, in_data=0x2A → accepted, in_ready pulse, reg1=0x2A. COPY 1→6 → out_valid pulse, out_data=0x2A.
- Assert rst at MUL cycle 4 → busy, result_valid and all registers 0 immediately; after release, IMM 1 executes normally.
- WIDTH=16, MUL_EN=0: CALC MUL → single-cycle write of 0. ADD 0xFFFF+1 → 0x0000, carry dropped.
